// File: rtl/markov_pkg.sv
// Shared Markov definitions: generator state encoding, LFSR constants and default widths
// common to the learner and the generator.
package markov_pkg;

   localparam int SYM_W_DEF = 8;
   localparam int CNT_W_DEF = 8;
   localparam int DEPTH_DEF = 16;

   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

   typedef enum logic [2:0] {
      IDLE,
      SUM,
      DRAW,
      SELECT,
      FINISH
   } gen_state_e;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/markov_lfsr16.sv
// 16-bit Galois LFSR; a zero seed falls back to the default so the register never locks up.
module markov_lfsr16
   import markov_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        advance,
   output logic [15:0] value
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value <= LFSR_DEFAULT;
      end else if (load) begin
         value <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
      end else if (advance) begin
         value <= lfsr_step(value);
      end
   end

endmodule

// File: rtl/markov_generator.sv
// Draws the next symbol from a transition table, weighting each matching entry by its count.
// One scan sums the matching counts, a second scan walks the cumulative sum to the random target.
module markov_generator
   import markov_pkg::*;
#(
   parameter int SYM_W = SYM_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tbl_wr_en,
   input  logic [IDX_W-1:0] tbl_wr_idx,
   input  logic [SYM_W-1:0] tbl_wr_prev,
   input  logic [SYM_W-1:0] tbl_wr_next,
   input  logic [CNT_W-1:0] tbl_wr_count,
   input  logic [IDX_W:0]   tbl_size,
   input  logic             seed_load,
   input  logic [15:0]      seed,
   input  logic             start,
   input  logic [SYM_W-1:0] cur_sym,
   output logic             busy,
   output logic             out_valid,
   output logic [SYM_W-1:0] out_sym,
   output logic             no_match
);

   localparam int TOT_W = CNT_W + IDX_W;

   gen_state_e       state;
   logic [SYM_W-1:0] tbl_prev [DEPTH];
   logic [SYM_W-1:0] tbl_next [DEPTH];
   logic [CNT_W-1:0] tbl_cnt  [DEPTH];

   logic [SYM_W-1:0] sym_q;
   logic [SYM_W-1:0] res_sym;
   logic [IDX_W:0]   n_q;
   logic [IDX_W-1:0] idx;
   logic [TOT_W-1:0] total;
   logic [TOT_W-1:0] acc;
   logic [TOT_W-1:0] target;
   logic             miss;

   logic [15:0]       lfsr_value;
   logic [IDX_W:0]    size_clamped;
   logic              entry_match;
   logic              last_idx;
   logic [TOT_W-1:0]  entry_cnt;
   logic [TOT_W-1:0]  acc_next;
   logic [TOT_W+15:0] product;

   assign size_clamped = (tbl_size > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : tbl_size;
   assign entry_match  = (tbl_prev[idx] == sym_q);
   assign last_idx     = ({1'b0, idx} == (n_q - 1'b1));
   assign entry_cnt    = entry_match ? TOT_W'(tbl_cnt[idx]) : '0;
   assign acc_next     = acc + entry_cnt;
   assign product      = (TOT_W+16)'(lfsr_value) * (TOT_W+16)'(total);

   markov_lfsr16 u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load    (seed_load && (state == IDLE)),
      .seed    (seed),
      .advance ((state == FINISH) && !miss),
      .value   (lfsr_value)
   );

   // The table is only writable while idle so a draw always scans a stable snapshot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_prev[i] <= '0;
            tbl_next[i] <= '0;
            tbl_cnt[i]  <= '0;
         end
      end else if (tbl_wr_en && (state == IDLE)) begin
         tbl_prev[tbl_wr_idx] <= tbl_wr_prev;
         tbl_next[tbl_wr_idx] <= tbl_wr_next;
         tbl_cnt[tbl_wr_idx]  <= tbl_wr_count;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_sym   <= '0;
         no_match  <= 1'b0;
         sym_q     <= '0;
         res_sym   <= '0;
         n_q       <= '0;
         idx       <= '0;
         total     <= '0;
         acc       <= '0;
         target    <= '0;
         miss      <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sym_q <= cur_sym;
                  n_q   <= size_clamped;
                  idx   <= '0;
                  total <= '0;
                  state <= (size_clamped != '0) ? SUM : DRAW;
               end
            end
            SUM: begin
               busy  <= 1'b1;
               total <= total + entry_cnt;
               idx   <= idx + 1'b1;
               if (last_idx) begin
                  state <= DRAW;
               end
            end
            DRAW: begin
               busy <= 1'b1;
               if (total == '0) begin
                  miss  <= 1'b1;
                  state <= FINISH;
               end else begin
                  miss   <= 1'b0;
                  target <= product[TOT_W+15:16];
                  acc    <= '0;
                  idx    <= '0;
                  state  <= SELECT;
               end
            end
            // Zero-count entries never push acc past target, so they cannot be picked.
            SELECT: begin
               busy <= 1'b1;
               acc  <= acc_next;
               idx  <= idx + 1'b1;
               if (entry_match && (acc_next > target)) begin
                  res_sym <= tbl_next[idx];
                  state   <= FINISH;
               end else if (last_idx) begin
                  miss  <= 1'b1;
                  state <= FINISH;
               end
            end
            FINISH: begin
               busy      <= 1'b0;
               out_valid <= 1'b1;
               out_sym   <= miss ? '0 : res_sym;
               no_match  <= miss;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_markov_generator.sv
// Randomized scoreboard bench for markov_generator against a table-level reference model.
module tb_markov_generator;

   logic        clk = 1'b0;
   logic        reset;
   logic        tbl_wr_en;
   logic [3:0]  tbl_wr_idx;
   logic [7:0]  tbl_wr_prev;
   logic [7:0]  tbl_wr_next;
   logic [7:0]  tbl_wr_count;
   logic [4:0]  tbl_size;
   logic        seed_load;
   logic [15:0] seed;
   logic        start;
   logic [7:0]  cur_sym;
   logic        busy;
   logic        out_valid;
   logic [7:0]  out_sym;
   logic        no_match;

   markov_generator dut (
      .clk          (clk),
      .reset        (reset),
      .tbl_wr_en    (tbl_wr_en),
      .tbl_wr_idx   (tbl_wr_idx),
      .tbl_wr_prev  (tbl_wr_prev),
      .tbl_wr_next  (tbl_wr_next),
      .tbl_wr_count (tbl_wr_count),
      .tbl_size     (tbl_size),
      .seed_load    (seed_load),
      .seed         (seed),
      .start        (start),
      .cur_sym      (cur_sym),
      .busy         (busy),
      .out_valid    (out_valid),
      .out_sym      (out_sym),
      .no_match     (no_match)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] sym;
      logic       nm;
   } exp_t;

   exp_t expQ[$];
   int   assertCount = 0;
   int   failCount   = 0;
   int   cnt41 = 0, cnt42 = 0, cnt43 = 0;

   // Reference model: table contents, size and random state as the generator should see them.
   int          mPrev [16];
   int          mNext [16];
   int          mCnt  [16];
   int          mSize = 0;
   logic [15:0] mLfsr = 16'hACE1;

   function automatic logic [15:0] lfsrNext(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      assertCount++;
      if (actual != expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic modelClear();
      for (int i = 0; i < 16; i++) begin
         mPrev[i] = 0;
         mNext[i] = 0;
         mCnt[i]  = 0;
      end
      mLfsr = 16'hACE1;
   endtask

   task automatic modelDraw(input int cur, output int sym, output int nm, output int lat);
      int n, total, target, acc, k;
      n     = (mSize > 16) ? 16 : mSize;
      total = 0;
      for (int i = 0; i < n; i++) if (mPrev[i] == cur) total += mCnt[i];
      sym = 0;
      nm  = 1;
      lat = n + 2;
      if (total != 0) begin
         target = int'((longint'(mLfsr) * longint'(total)) >> 16);
         acc = 0;
         k   = -1;
         for (int i = 0; i < n; i++) begin
            if (k < 0 && mPrev[i] == cur) begin
               acc += mCnt[i];
               if (acc > target) k = i;
            end
         end
         sym   = mNext[k];
         nm    = 0;
         lat   = n + k + 3;
         mLfsr = lfsrNext(mLfsr);
      end
   endtask

   task automatic writeEntry(input int i, input int prev, input int nxt, input int cnt);
      @(negedge clk);
      tbl_wr_en    = 1'b1;
      tbl_wr_idx   = 4'(i);
      tbl_wr_prev  = 8'(prev);
      tbl_wr_next  = 8'(nxt);
      tbl_wr_count = 8'(cnt);
      @(negedge clk);
      tbl_wr_en = 1'b0;
      mPrev[i] = prev;
      mNext[i] = nxt;
      mCnt[i]  = cnt;
   endtask

   task automatic loadSeed(input logic [15:0] s);
      @(negedge clk);
      seed_load = 1'b1;
      seed      = s;
      @(negedge clk);
      seed_load = 1'b0;
      mLfsr = (s == 16'h0000) ? 16'hACE1 : s;
   endtask

   task automatic loadDefaultTable();
      writeEntry(0, 8'h41, 8'h42, 3);
      writeEntry(1, 8'h41, 8'h43, 1);
      writeEntry(2, 8'h42, 8'h41, 5);
      tbl_size = 5'd3;
      mSize    = 3;
   endtask

   // Issues one draw, queues the model's answer, and checks timing of busy and the strobe.
   task automatic applyStimulus(input int cur);
      int   eSym, eNm, eLat, cycles, busyCnt;
      bit   seen;
      exp_t e;
      modelDraw(cur, eSym, eNm, eLat);
      e.sym = 8'(eSym);
      e.nm  = eNm[0];
      expQ.push_back(e);
      @(negedge clk);
      start   = 1'b1;
      cur_sym = 8'(cur);
      @(posedge clk);
      @(negedge clk);
      start   = 1'b0;
      cycles  = 0;
      busyCnt = 0;
      seen    = 1'b0;
      while (!seen && cycles < 300) begin
         if (out_valid) begin
            seen = 1'b1;
         end else begin
            if (busy) busyCnt++;
            @(posedge clk);
            cycles++;
            @(negedge clk);
         end
      end
      checkOutput("out_valid arrives", int'(seen), 1);
      checkOutput("latency", cycles, eLat);
      checkOutput("busy cycles", busyCnt, eLat - 1);
      @(negedge clk);
      checkOutput("strobe width", int'(out_valid), 0);
   endtask

   // Monitor: every result strobe must match the oldest outstanding prediction.
   initial begin
      forever begin
         @(negedge clk);
         if (out_valid) begin
            if (expQ.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL unexpected out_valid: got sym %0h with nothing outstanding", out_sym);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               checkOutput("out_sym", int'(out_sym), int'(e.sym));
               checkOutput("no_match", int'(no_match), int'(e.nm));
            end
            if (!no_match) begin
               if (out_sym == 8'h41) cnt41++;
               if (out_sym == 8'h42) cnt42++;
               if (out_sym == 8'h43) cnt43++;
            end
         end
      end
   end

   initial begin
      reset        = 1'b0;
      tbl_wr_en    = 1'b0;
      tbl_wr_idx   = '0;
      tbl_wr_prev  = '0;
      tbl_wr_next  = '0;
      tbl_wr_count = '0;
      tbl_size     = '0;
      seed_load    = 1'b0;
      seed         = '0;
      start        = 1'b0;
      cur_sym      = '0;
      modelClear();
      repeat (3) @(negedge clk);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset out_valid", int'(out_valid), 0);
      checkOutput("reset out_sym", int'(out_sym), 0);
      checkOutput("reset no_match", int'(no_match), 0);
      reset = 1'b1;

      loadDefaultTable();
      applyStimulus(8'h42);
      applyStimulus(8'h50);
      applyStimulus(8'h41);

      $display("[TB] distribution run");
      loadSeed(16'h1234);
      cnt41 = 0;
      cnt42 = 0;
      cnt43 = 0;
      for (int i = 0; i < 4000; i++) applyStimulus(8'h41);
      checkOutput("dist 0x42 low bound", int'(cnt42 >= 2850), 1);
      checkOutput("dist 0x42 high bound", int'(cnt42 <= 3150), 1);
      checkOutput("dist 0x43 remainder", cnt43, 4000 - cnt42);
      checkOutput("dist never 0x41", cnt41, 0);

      $display("[TB] seeding runs");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      modelClear();
      loadDefaultTable();
      for (int i = 0; i < 100; i++) applyStimulus(8'h41);
      loadSeed(16'h0000);
      for (int i = 0; i < 100; i++) applyStimulus(8'h41);
      for (int r = 0; r < 2; r++) begin
         loadSeed(16'h1234);
         for (int i = 0; i < 50; i++) applyStimulus(8'h41);
      end

      $display("[TB] hazards");
      fork
         applyStimulus(8'h42);
         begin
            repeat (4) @(negedge clk);
            tbl_wr_en    = 1'b1;
            tbl_wr_idx   = 4'd2;
            tbl_wr_prev  = 8'h42;
            tbl_wr_next  = 8'h44;
            tbl_wr_count = 8'd9;
            @(negedge clk);
            tbl_wr_en = 1'b0;
         end
      join
      applyStimulus(8'h42);
      fork
         applyStimulus(8'h41);
         begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      repeat (12) @(negedge clk);
      writeEntry(10, 8'h42, 8'h44, 5);
      tbl_size = 5'd20;
      mSize    = 20;
      for (int i = 0; i < 6; i++) applyStimulus(8'h42);
      applyStimulus(8'h41);

      $display("[TB] randomized phase");
      for (int i = 0; i < 8; i++) begin
         writeEntry(i, 8'h41 + $urandom_range(0, 2), $urandom_range(0, 255),
                    ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255));
      end
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 9) == 0) loadSeed(16'($urandom_range(0, 65535)));
         if ($urandom_range(0, 4) == 0) begin
            tbl_size = 5'($urandom_range(0, 20));
            mSize    = int'(tbl_size);
         end
         applyStimulus(8'h41 + $urandom_range(0, 3));
      end

      $display("[TB] reset during SELECT");
      loadDefaultTable();
      @(negedge clk);
      start   = 1'b1;
      cur_sym = 8'h42;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      checkOutput("busy before reset", int'(busy), 1);
      reset = 1'b0;
      #1;
      checkOutput("async reset busy", int'(busy), 0);
      checkOutput("async reset out_valid", int'(out_valid), 0);
      checkOutput("async reset out_sym", int'(out_sym), 0);
      @(negedge clk);
      reset = 1'b1;
      modelClear();
      applyStimulus(8'h42);

      repeat (5) @(negedge clk);
      checkOutput("scoreboard drained", expQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/markov_generator.md
Name: markov_generator

Overview:
- Generation side of the Markov learning flow: holds a transition table of (prev_symbol, next_symbol, count) entries loaded from the learner.
- Given a current symbol, draws the next symbol with probability proportional to count.
- Uses a 16-bit LFSR and two sequential table scans.

Parameters:
SYM_W, 8, symbol width
CNT_W, 8, per-entry transition count width
DEPTH, 16, table entries
IDX_W, 4, index width (log2 DEPTH)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tbl_wr_en  in  1  table write strobe
tbl_wr_idx  in  IDX_W  entry to write
tbl_wr_prev  in  SYM_W  entry's previous symbol
tbl_wr_next  in  SYM_W  entry's next symbol
tbl_wr_count  in  CNT_W  entry's count
tbl_size  in  IDX_W+1  number of valid entries (0..DEPTH)
seed_load  in  1  load LFSR from seed
seed  in  16  LFSR seed
start  in  1  request one draw
cur_sym  in  SYM_W  current symbol, sampled on start
busy  out  1  draw in progress
out_valid  out  1  one-cycle result strobe
out_sym  out  SYM_W  drawn symbol (0 when no_match)
no_match  out  1  qualifies out_valid: no entry for cur_sym

Behaviour:
- Reset (async, active-low):
  - state=IDLE.
  - busy=0, out_valid=0, out_sym=0, no_match=0.
  - All table counts=0; LFSR=0xACE1.
- Table: internal register array, written on tbl_wr_en only in IDLE; writes while busy are dropped. tbl_size is sampled on start and clamped to DEPTH.
- LFSR: 16-bit Galois, taps 0xB400, shifts once per completed draw.
  - seed_load (IDLE only) loads seed; a seed of 0 loads 0xACE1.
  - A draw that completes with no_match does not shift the LFSR.
- States IDLE, SUM, DRAW, SELECT, FINISH:
  - IDLE:
    - start=1 latches cur_sym and N=clamped tbl_size, then goes to SUM (N>0) or DRAW (N=0).
    - idx=0, total=0, busy=1 from the next cycle.
    - start while busy is ignored.
  - SUM: one entry per cycle; if prev==cur_sym, total += count (width CNT_W+IDX_W, cannot overflow). Leaves after idx=N-1.
  - DRAW (1 cycle):
    - total==0 -> FINISH with no_match=1.
    - Otherwise target = (lfsr * total) >> 16, so 0 <= target < total. acc=0, idx=0, then SELECT.
  - SELECT:
    - One entry per cycle; for a matching entry, acc_next = acc + count.
    - First entry with acc_next > target -> out_sym=next, then FINISH; the scan stops early.
    - Termination is guaranteed, since the acc sum reaches total > target.
  - FINISH (1 cycle): out_valid=1 for exactly this cycle, busy=0 next cycle, shift LFSR (if not no_match), return to IDLE.
  - out_sym and no_match hold until the next start.
- Latency from the start sampling edge to out_valid = N + 1 + (k+1) + 1 cycles, where k is the selected index. For no_match: N + 2.
- Zero-count matching entries are never selected.
- Mid-operation reset aborts immediately: outputs go to their reset values and the table is cleared.

Decomposition:
- Shared package markov_pkg holds:
  - state encoding (IDLE..FINISH);
  - LFSR_TAPS=16'hB400 and LFSR_DEFAULT=16'hACE1;
  - default SYM_W/CNT_W/DEPTH constants, shared with the learner.
- One sub-module markov_lfsr16 (clk, reset, load, seed, advance, value).
- Table, scan counters and FSM stay in markov_generator.

Test Plan:
- Table setup for all tests (tbl_size=3):
  - entry0 = (0x41 -> 0x42, 3)
  - entry1 = (0x41 -> 0x43, 1)
  - entry2 = (0x42 -> 0x41, 5)
- Deterministic: start with cur_sym=0x42 -> out_sym=0x41, no_match=0, out_valid exactly 8 cycles after start, busy high for 7 cycles, single-cycle strobe.
- Distribution: 4000 draws with cur_sym=0x41, seed=0x1234 -> 0x42 count within 3000±150, 0x43 the remainder, never 0x41.
- No match: cur_sym=0x50 -> out_valid after 5 cycles, no_match=1, out_sym=0, LFSR unchanged (next 0x41 draw equals the draw taken without this request).
- Seeding: seed_load seed=0 vs reset default -> identical 100-draw sequences; two runs with seed=0x1234 are identical.
- Hazards:
  - tbl_wr_en changing entry2 during a busy draw -> ignored, and the result still follows the original table.
  - start pulsed while busy -> no extra out_valid.
  - tbl_size=20 -> treated as 16.
- Reset: assert reset in the 2nd SELECT cycle -> busy=0, out_valid=0 asynchronously; after release, start with cur_sym=0x42 -> no_match=1 (table cleared).
